// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared FIFO geometry defaults and arbiter state encoding
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_WIDTH;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick starting just after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_id,
  output logic               gnt_vld
);
  logic [IW-1:0] idx;
  // scan farthest to nearest so the nearest valid requester after ptr wins
  always_comb begin
    gnt_id = '0;
    gnt_vld = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        gnt_id = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin burst arbiter sharing the sync_fifo write port
module sync_fifo_wr_arb
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_BURST = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arb_en,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  input  logic                               fifo_full,
  input  logic [FIFO_ADDR_WIDTH:0]           fifo_data_cnt,
  output logic                               fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0]         fifo_wr_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam int SW = FIFO_ADDR_WIDTH + 2;
  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, pick;
  logic [CW-1:0] beat_cnt;
  logic pick_vld, space, accept, burst_end, start;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt_id(pick),
    .gnt_vld(pick_vld)
  );
  // the registered write in flight is not yet in fifo_data_cnt, so count it here
  assign space = !fifo_full && ({1'b0, fifo_data_cnt} + SW'(fifo_wr_en)) < SW'(DEPTH);
  assign accept = state == BURST && req_valid[grant_id] && space;
  assign burst_end = state == BURST && (!req_valid[grant_id] ||
                     (accept && (req_last[grant_id] || beat_cnt == CW'(MAX_BURST - 1))));
  assign start = state == IDLE && arb_en && pick_vld;
  assign req_ready = accept ? NUM_REQ'(1) << grant_id : '0;
  assign busy = state == BURST;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: grant from IDLE, release on last, full burst or dropped valid
  always_comb state_nxt = start ? BURST : (burst_end ? IDLE : state);
  // grant, round-robin pointer and beat counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant_id <= '0;
      rr_ptr <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      if (start) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end else if (accept) beat_cnt <= beat_cnt + CW'(1);
      if (burst_end) rr_ptr <= grant_id;
    end
  // registered FIFO write, one cycle after the accepted beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) fifo_wr_data <= req_data[grant_id*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
    end
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb_sync_fifo_wr_arb: directed checks of the write arbiter against a FIFO model
module tb_sync_fifo_wr_arb;
  logic clk, rst_n, arb_en, fifo_full, fifo_wr_en, busy, rd, pb;
  logic [3:0] req_valid, req_last, req_ready, rdy;
  logic [127:0] req_data;
  logic [1:0] grant_id;
  logic [8:0] fifo_data_cnt;
  logic [31:0] fifo_wr_data;
  logic [31:0] fq[$];
  int fcnt = 0, ovf = 0, n_chk = 0, n_err = 0, w, n, ng, wc;
  int seq[4];
  int g[5];
  sync_fifo_wr_arb dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .fifo_full(fifo_full),
    .fifo_data_cnt(fifo_data_cnt), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // depth-256 FIFO model driven by the arbiter's write port
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (rd && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr_en) begin
        if (fq.size() >= 256) ovf++;
        else fq.push_back(fifo_wr_data);
      end
      fcnt <= fq.size();
    end
  assign fifo_data_cnt = 9'(fcnt);
  assign fifo_full = fcnt == 256;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0;
    arb_en = 1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    rd = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask
  task automatic send(input int p, input logic [31:0] d, input logic l, output int waited);
    req_valid[p] = 1'b1;
    req_data[p*32 +: 32] = d;
    req_last[p] = l;
    #1;
    waited = 0;
    while (!req_ready[p] && waited < 600) begin
      tick();
      waited++;
    end
    check("send_rdy", 32'(req_ready[p]), 1);
    tick();
  endtask
  initial begin
    rst_n = 1;
    arb_en = 0;
    rd = 0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    #1 rst_n = 0;
    #1;
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(req_ready), 0);
    // single producer burst of 4 ending on last
    do_reset();
    send(0, 2, 0, w);
    check("t1_lat", w, 1);
    check("t1_wr_en", 32'(fifo_wr_en), 1);
    check("t1_wr_data", fifo_wr_data, 2);
    send(0, 4, 0, w);
    send(0, 6, 0, w);
    send(0, 8, 1, w);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_wr_last", fifo_wr_data, 8);
    req_valid = '0;
    tick();
    check("t1_wr_off", 32'(fifo_wr_en), 0);
    check("t1_cnt", fcnt, 4);
    check("t1_q0", fq[0], 2);
    check("t1_q1", fq[1], 4);
    check("t1_q3", fq[3], 8);
    // all four producers continuously valid, never last
    do_reset();
    req_valid = 4'hF;
    for (int p = 0; p < 4; p++) begin
      seq[p] = 0;
      req_data[p*32 +: 32] = 32'(p * 256);
    end
    pb = 0;
    ng = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      rdy = req_ready;
      tick();
      for (int p = 0; p < 4; p++)
        if (rdy[p]) begin
          seq[p]++;
          req_data[p*32 +: 32] = 32'(p * 256 + seq[p]);
        end
      if (busy && !pb && ng < 5) begin
        g[ng] = int'(grant_id);
        ng++;
      end
      pb = busy;
    end
    req_valid = '0;
    tick();
    check("t2_ngrants", ng, 5);
    check("t2_g0", g[0], 0);
    check("t2_g1", g[1], 1);
    check("t2_g2", g[2], 2);
    check("t2_g3", g[3], 3);
    check("t2_g4", g[4], 0);
    check("t2_seq0", seq[0], 8);
    check("t2_seq3", seq[3], 4);
    check("t2_cnt", fcnt, 20);
    check("t2_q4", fq[4], 256);
    check("t2_q19", fq[19], 7);
    // fill the FIFO from producer 1 with no reads
    do_reset();
    for (int i = 0; i < 256; i++) send(1, 32'(i), 1'b0, w);
    req_data[63:32] = 999;
    repeat (3) tick();
    check("t3_cnt_full", fcnt, 256);
    check("t3_full", 32'(fifo_full), 1);
    check("t3_ready", 32'(req_ready[1]), 0);
    check("t3_busy", 32'(busy), 1);
    check("t3_wr_en", 32'(fifo_wr_en), 0);
    rd = 1;
    tick();
    rd = 0;
    wc = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (fifo_wr_en) wc++;
    end
    check("t3_one_more", wc, 1);
    check("t3_cnt_after", fcnt, 256);
    check("t3_q_last", fq[255], 999);
    check("t3_q_first", fq[0], 1);
    check("t3_ovf", ovf, 0);
    req_valid = '0;
    // early release by producer 2 while producer 3 waits
    do_reset();
    req_valid[3] = 1;
    req_data[127:96] = 3000;
    send(2, 20, 0, w);
    check("t4_grant", 32'(grant_id), 2);
    check("t4_nongrant", 32'(req_ready[3]), 0);
    send(2, 21, 0, w);
    req_valid[2] = 0;
    tick();
    check("t4_release", 32'(busy), 0);
    tick();
    check("t4_busy3", 32'(busy), 1);
    check("t4_grant3", 32'(grant_id), 3);
    check("t4_cnt", fcnt, 2);
    check("t4_q0", fq[0], 20);
    check("t4_q1", fq[1], 21);
    check("t4_ready3", 32'(req_ready), 8);
    req_valid = '0;
    // reset in the middle of producer 1's burst
    do_reset();
    req_valid[1] = 1;
    req_data[63:32] = 60;
    send(0, 50, 1, w);
    send(1, 60, 0, w);
    send(1, 61, 0, w);
    check("t5_pre_grant", 32'(grant_id), 1);
    check("t5_pre_data", fifo_wr_data, 61);
    rst_n = 0;
    #1;
    check("t5_wr_en", 32'(fifo_wr_en), 0);
    check("t5_wr_data", fifo_wr_data, 0);
    check("t5_grant", 32'(grant_id), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_ready", 32'(req_ready), 0);
    #29 rst_n = 1;
    n = 0;
    tick();
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("t5_regrant", 32'(busy), 1);
    check("t5_first", 32'(grant_id), 0);
    req_valid = '0;
    // arb_en dropped during a 4-beat burst
    do_reset();
    req_valid[1] = 1;
    send(0, 70, 0, w);
    arb_en = 0;
    send(0, 71, 0, w);
    send(0, 72, 0, w);
    send(0, 73, 0, w);
    check("t6_end", 32'(busy), 0);
    check("t6_last", fifo_wr_data, 73);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_blocked", 32'(busy), 0);
    end
    check("t6_grant_hold", 32'(grant_id), 0);
    check("t6_cnt", fcnt, 4);
    arb_en = 1;
    tick();
    check("t6_resume", 32'(busy), 1);
    check("t6_grant1", 32'(grant_id), 1);
    req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
